// File: rtl/bus_sched_if.sv
// ============================================================================
// Module      : bus_sched_if
// Description : Request/grant bundle between bus masters and the bus_sched
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_sched_if #(
  parameter int NREQ = 8
);
  logic [NREQ-1:0] bus_req;
  logic            bus_rd;
  logic            bus_wr;
  logic            bus_ready;
  logic [NREQ-1:0] bus_ack;
  logic [2:0]      bus_owner;
  logic            bus_owner_vld;
  logic            bus_timeout;

  modport master (
    output bus_req, bus_rd, bus_wr, bus_ready,
    input  bus_ack, bus_owner, bus_owner_vld, bus_timeout
  );

  modport slave (
    input  bus_req, bus_rd, bus_wr, bus_ready,
    output bus_ack, bus_owner, bus_owner_vld, bus_timeout
  );
endinterface

`default_nettype wire

// File: rtl/bus_sched.sv
// ============================================================================
// Module      : bus_sched
// Description : Registered grant-holding bus arbiter with one idle turnaround
//               cycle between owners and a stalled-transfer watchdog.
//               Define BUS_SCHED_RR_EN for round-robin, else fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_sched #(
  parameter int NREQ    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  bus_sched_if.slave   bus
);

  localparam logic [1:0]      c_idle      = 2'd0;
  localparam logic [1:0]      c_owned     = 2'd1;
  localparam logic [1:0]      c_turn      = 2'd2;
  localparam logic [7:0]      c_wdog_last = 8'(TIMEOUT - 1);
  localparam bit              c_wdog_en   = (TIMEOUT != 0);
  localparam logic [NREQ-1:0] c_one       = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_ack;
  logic [2:0]      r_owner;
  logic            r_vld;
  logic            r_timeout;
  logic [7:0]      r_wdog;
  logic [2:0]      r_last;

  logic [7:0]      w_req8;
  logic [2:0]      w_idx;
  logic [2:0]      w_win;
  logic            w_found;
  logic            w_owner_req;
  logic            w_stall;
  logic            w_fire;

  assign w_req8      = 8'(bus.bus_req);
  assign w_owner_req = |(bus.bus_req & r_ack);
  assign w_stall     = (bus.bus_rd | bus.bus_wr) & ~bus.bus_ready;
  assign w_fire      = c_wdog_en && w_stall && (r_wdog == c_wdog_last);

  // Loops run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
`ifdef BUS_SCHED_RR_EN
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = 3'((int'(r_last) + k) % NREQ);
      if (w_req8[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = 3'(i);
      if (w_req8[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_ack     <= '0;
      r_owner   <= 3'd0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
      r_wdog    <= 8'd0;
      r_last    <= 3'(NREQ - 1);
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        c_owned: begin
          if (!w_owner_req || w_fire) begin
            r_state   <= c_turn;
            r_ack     <= '0;
            r_owner   <= 3'd0;
            r_vld     <= 1'b0;
            r_wdog    <= 8'd0;
            r_timeout <= w_owner_req;
          end else if (!w_stall) begin
            r_wdog <= 8'd0;
          end else if (r_wdog != 8'hFF) begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        // IDLE and TURN arbitrate identically; an illegal code falls in here too.
        default: begin
          r_wdog <= 8'd0;
          if (w_found) begin
            r_state <= c_owned;
            r_ack   <= c_one << w_win;
            r_owner <= w_win;
            r_vld   <= 1'b1;
            r_last  <= w_win;
          end else begin
            r_state <= c_idle;
            r_ack   <= '0;
            r_owner <= 3'd0;
            r_vld   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.bus_ack       = r_ack;
  assign bus.bus_owner     = r_owner;
  assign bus.bus_owner_vld = r_vld;
  assign bus.bus_timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_sched.sv
// ============================================================================
// Module      : tb_bus_sched
// Description : Self-checking bench for bus_sched (TIMEOUT=4) against an
//               owner/stall-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_sched;

  localparam int NREQ    = 8;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Reference model: who owns the bus, consecutive stalled cycles, last winner.
  int   m_owner;
  int   m_consec;
  int   m_last;
  bit   m_to;

  bus_sched_if #(.NREQ(NREQ)) bif ();

  bus_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] req, input int last);
`ifdef BUS_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_consec = 0;
    m_last   = NREQ - 1;
    m_to     = 1'b0;
  endtask

  task automatic model_step();
    bit stalled;
    int w;
    stalled = (bif.bus_rd || bif.bus_wr) && !bif.bus_ready;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!bif.bus_req[m_owner]) begin
        m_owner  = -1;
        m_consec = 0;
      end else begin
        m_consec = stalled ? m_consec + 1 : 0;
        if (TIMEOUT != 0 && m_consec >= TIMEOUT) begin
          m_to     = 1'b1;
          m_owner  = -1;
          m_consec = 0;
        end
      end
    end else begin
      w = pick(bif.bus_req, m_last);
      if (w >= 0) begin
        m_owner  = w;
        m_last   = w;
        m_consec = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] e_ack;
    e_ack = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    chk({tag, ".ack"},   32'(bif.bus_ack), 32'(e_ack));
    chk({tag, ".owner"}, 32'(bif.bus_owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({tag, ".vld"},   32'(bif.bus_owner_vld), 32'(m_owner >= 0));
    chk({tag, ".to"},    32'(bif.bus_timeout), 32'(m_to));
  endtask

  task automatic drive(input logic [7:0] req, input logic rd, input logic wr, input logic rdy);
    bif.bus_req   = req;
    bif.bus_rd    = rd;
    bif.bus_wr    = wr;
    bif.bus_ready = rdy;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    int held;
    int grants;
    int prev_owner;
    int budget;
    logic [7:0] r;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // First grant from IDLE.
    drive(8'h02, 1'b0, 1'b0, 1'b0);
    cycle("grant1");
    chk("grant1_ack", 32'(bif.bus_ack), 32'h02);
    chk("grant1_owner", 32'(bif.bus_owner), 32'd1);
    cycle("grant1_hold");

    // Asynchronous reset mid-grant.
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    #1 rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    cycle("post_rst");

    // Two masters, owner drops after 3 cycles and re-raises next cycle.
    held = 0; grants = 0; budget = 0;
    while (grants < 4 && budget < 60) begin
      if (m_owner >= 0) begin
        held++;
        drive((held >= 3) ? (8'h03 & ~8'(1 << m_owner)) : 8'h03, 1'b0, 1'b0, 1'b0);
      end else begin
        held = 0;
        drive(8'h03, 1'b0, 1'b0, 1'b0);
      end
      prev_owner = m_owner;
      cycle("alt");
      if (prev_owner < 0 && m_owner >= 0) begin
`ifdef BUS_SCHED_RR_EN
        chk("alt_order", 32'(bif.bus_owner), 32'(grants % 2));
`else
        chk("alt_order", 32'(bif.bus_owner), 32'd0);
`endif
        grants++;
      end
      budget++;
    end
    chk("alt_budget", 32'(grants), 32'd4);

    // No preemption of owner 0 by master 1.
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    cycle("np_drain0");
    cycle("np_drain1");
    drive(8'h01, 1'b0, 1'b0, 1'b0);
    cycle("np_grant");
    drive(8'h03, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("np_hold");
      chk("np_ack", 32'(bif.bus_ack), 32'h01);
    end

    // Watchdog timeout after 4 stalled cycles, then regrant.
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    cycle("wd_drain0");
    cycle("wd_drain1");
    drive(8'h02, 1'b1, 1'b0, 1'b0);
    cycle("wd_grant");
    chk("wd_grant_ack", 32'(bif.bus_ack), 32'h02);
    for (int i = 1; i <= 3; i++) begin
      cycle("wd_stall");
      chk("wd_no_to", 32'(bif.bus_timeout), 32'd0);
    end
    cycle("wd_fire");
    chk("wd_to", 32'(bif.bus_timeout), 32'd1);
    chk("wd_to_ack", 32'(bif.bus_ack), 32'h00);
    cycle("wd_regrant");
    chk("wd_regrant_ack", 32'(bif.bus_ack), 32'h02);
    chk("wd_regrant_to", 32'(bif.bus_timeout), 32'd0);

    // bus_ready on the would-fire cycle wins and restarts the count.
    for (int i = 1; i <= 3; i++) cycle("rdy_stall");
    drive(8'h02, 1'b1, 1'b0, 1'b1);
    cycle("rdy_win");
    chk("rdy_no_to", 32'(bif.bus_timeout), 32'd0);
    chk("rdy_hold", 32'(bif.bus_ack), 32'h02);
    drive(8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cycle("rdy_restall");
    chk("rdy_still_held", 32'(bif.bus_ack), 32'h02);
    cycle("rdy_refire");
    chk("rdy_refire_to", 32'(bif.bus_timeout), 32'd1);

    // Owner 2 drops while master 5 raises in the same cycle.
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    cycle("hand_drain0");
    cycle("hand_drain1");
    drive(8'h04, 1'b0, 1'b0, 1'b0);
    cycle("hand_own2");
    cycle("hand_hold2");
    drive(8'h20, 1'b0, 1'b0, 1'b0);
    cycle("hand_turn");
    chk("hand_turn_ack", 32'(bif.bus_ack), 32'h00);
    cycle("hand_own5");
    chk("hand_ack5", 32'(bif.bus_ack), 32'h20);
    chk("hand_owner5", 32'(bif.bus_owner), 32'd5);

    // Randomized traffic; the current owner usually keeps its request.
    for (int i = 0; i < 1500; i++) begin
      r = 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      drive(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
